warp_issue_arbiter: RTL
=======================

Name: warp_issue_arbiter

Overview:
- Shares one execution-unit issue port between the per-warp wait buffers of the multi-warp dispatcher.
- Picks one ready warp per handshake by round-robin and holds that grant stable until the handshake completes.
- Limits in-flight operations with a credit counter that is returned by writeback pulses.
- Sits between the dispatcher wait buffers and the first functional unit of the compute unit.

Parameters:
- NumWarps, 8, number of requesting warps (≥2).
- InstDataWidth, 48, width of the per-warp payload (pc, act_mask, decoded inst), passed through unchanged.
- MaxOutstanding, 4, maximum issued-but-not-written-back operations (≥1).
- CntWidth, $clog2(MaxOutstanding+1), width of the credit counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- warp_req_i  in  NumWarps  warp w has an instruction ready to issue.
- warp_data_i  in  NumWarps*InstDataWidth  payload; slice w belongs to warp w.
- warp_gnt_o  out  NumWarps  one-hot; set in the handshake cycle of the granted warp.
- eu_valid_o  out  1  issue valid to the execution unit.
- eu_ready_i  in  1  execution unit accepts.
- eu_warp_id_o  out  $clog2(NumWarps)  granted warp.
- eu_data_o  out  InstDataWidth  granted payload.
- wb_valid_i  in  1  one operation completed; returns one credit.
- outstanding_o  out  CntWidth  current in-flight count.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i high at a clock edge):
  - rr pointer=0, outstanding=0, lock=0, err_o=0.
  - While rst_i is high, eu_valid_o and warp_gnt_o are forced to 0.
- Issue is allowed when outstanding < MaxOutstanding.
  - A writeback in the same cycle does not unblock issue; there is no combinational path from wb_valid_i to eu_valid_o.
- Selection when unlocked: first w with warp_req_i[w]=1, scanning from pointer upward and wrapping at NumWarps-1 → 0.
- eu_valid_o = allowed && (lock || any req).
  - Combinational; 0-cycle latency from request to valid.
- eu_warp_id_o and eu_data_o come from the locked warp if lock=1, otherwise from the selected warp.
- State machine, 2 states:
  - IDLE → LOCKED when eu_valid_o && !eu_ready_i. Store lock_id = the selected warp.
  - LOCKED: no reselection. eu_warp_id_o and eu_data_o track warp lock_id (the requester must keep its data stable).
  - LOCKED → IDLE on handshake.
- Handshake (eu_valid_o && eu_ready_i):
  - warp_gnt_o[id]=1.
  - pointer ← (id+1) mod NumWarps.
  - outstanding +1.
- wb_valid_i alone: outstanding −1.
- Simultaneous handshake and wb_valid_i: outstanding unchanged.
- wb_valid_i with outstanding=0: counter stays 0, err_o ← 1.
- Locked warp drops warp_req_i before handshake:
  - lock cleared, eu_valid_o falls in the same cycle, err_o ← 1, pointer unchanged.
- Lock while credits are exhausted: cannot occur, because eu_valid_o requires allowed.
- Reset mid-lock or with credits outstanding: all state cleared. Writebacks arriving after reset set err_o (expected; the bench must quiesce first).
- Single requester: granted back-to-back every cycle while credits remain.

Optional Feature:
- Macro: BGPU_ISSUE_PERF_EN.
- When defined:
  - Adds output perf_issue_cnt_o, NumWarps*32 bits.
  - One 32-bit wrapping counter per warp, incremented on that warp's handshake, cleared by reset.
  - Adds output perf_stall_cnt_o, 32 bits: counts cycles with any req high and allowed=0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package bgpu_pkg: wid_t, NumWarps default, and issue payload struct issue_data_t (pc, act_mask, dec_inst).
- Sub-module issue_credit_counter:
  - Saturating up/down counter with inc_i, dec_i, max reached, and underflow-error output.
  - Instantiated once.
- Round-robin selection stays inline.

Test Plan:
- Reset, then req=8'b0000_0101, eu_ready_i=1: grants warp0, then warp2, then warp0. outstanding reaches 3; err_o=0.
- MaxOutstanding=4, all req high, ready=1, no wb: 4 grants in order 0,1,2,3, then eu_valid_o=0. One wb pulse → warp4 is granted the following cycle.
- req[5]=1, eu_ready_i=0 for 3 cycles while req[1] rises: eu_warp_id_o stays 5 and eu_data_o stays stable. Ready → gnt[5]; next grant is warp1.
- Handshake and wb_valid_i in the same cycle with outstanding=2: outstanding stays 2. wb with outstanding=0: stays 0, err_o=1 until reset.
- Locked warp3 drops req: eu_valid_o=0 that cycle, err_o=1. rst_i pulse mid-lock: eu_valid_o=0, outstanding=0, next grant starts from warp0.
- BGPU_ISSUE_PERF_EN defined: 10 grants to warp6 → perf_issue_cnt_o slice 6 = 10. Two cycles blocked at credit limit → perf_stall_cnt_o=2.

Source files
------------

// File: rtl/bgpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bgpu_pkg: shared warp-id, issue payload and arbiter state types.
// Rev 1.0
// ----------------------------------------------------------------------------
package bgpu_pkg;

  localparam int unsigned NumWarpsDefault = 8;
  localparam int unsigned WidWidth        = $clog2(NumWarpsDefault);

  typedef logic [WidWidth-1:0] wid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  act_mask;
    logic [7:0]  dec_inst;
  } issue_data_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/issue_credit_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// issue_credit_counter: saturating in-flight counter with underflow detect.
// Rev 1.0
// ----------------------------------------------------------------------------
module issue_credit_counter #(
  parameter int unsigned MAX_COUNT = 4,
  parameter int unsigned CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 max_o,
  output logic                 underflow_o
);

  localparam logic [CNT_WIDTH-1:0] c_max_val = CNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A simultaneous issue and return cancel out and never flag underflow.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != c_max_val) cnt_d = cnt_q + c_one;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d       = cnt_q - c_one;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign max_o = (cnt_q == c_max_val);

endmodule
`default_nettype wire

// File: rtl/warp_issue_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// warp_issue_arbiter: round-robin warp issue arbiter with credit-limited issue.
// Optional macro BGPU_ISSUE_PERF_EN adds per-warp issue and stall counters.
// Rev 1.0
// ----------------------------------------------------------------------------
module warp_issue_arbiter import bgpu_pkg::*; #(
  parameter int unsigned NumWarps       = NumWarpsDefault,
  parameter int unsigned InstDataWidth  = $bits(issue_data_t),
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumWarps-1:0]               warp_req_i,
  input  logic [NumWarps*InstDataWidth-1:0] warp_data_i,
  output logic [NumWarps-1:0]               warp_gnt_o,
  output logic                              eu_valid_o,
  input  logic                              eu_ready_i,
  output logic [$clog2(NumWarps)-1:0]       eu_warp_id_o,
  output logic [InstDataWidth-1:0]          eu_data_o,
  input  logic                              wb_valid_i,
  output logic [CntWidth-1:0]               outstanding_o,
  output logic                              err_o
`ifdef BGPU_ISSUE_PERF_EN
  ,
  output logic [NumWarps*32-1:0]            perf_issue_cnt_o,
  output logic [31:0]                       perf_stall_cnt_o
`endif
);

  localparam int unsigned            c_id_w    = $clog2(NumWarps);
  localparam logic [c_id_w-1:0]      c_last_id = c_id_w'(NumWarps - 1);
  localparam logic [c_id_w:0]        c_nwarps  = (c_id_w + 1)'(NumWarps);

  arb_state_e         state_q, state_d;
  logic [c_id_w-1:0]  ptr_q, ptr_d;
  logic [c_id_w-1:0]  lock_id_q, lock_id_d;
  logic               err_q, err_d;

  logic               w_any_req;
  logic               w_sel_found;
  logic [c_id_w:0]    w_scan;
  logic [c_id_w-1:0]  w_sel_id;
  logic [c_id_w-1:0]  w_cur_id;
  logic               w_credit_max;
  logic               w_underflow;
  logic               w_allowed;
  logic               w_locked;
  logic               w_lock_drop;
  logic               w_valid;
  logic               w_hs;

  assign w_any_req = |warp_req_i;

  // First requester at or above the pointer, wrapping at NumWarps-1.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = ptr_q;
    w_scan      = '0;
    for (int i = 0; i < int'(NumWarps); i++) begin
      w_scan = {1'b0, ptr_q} + (c_id_w + 1)'(i);
      if (w_scan >= c_nwarps) w_scan = w_scan - c_nwarps;
      if (!w_sel_found && warp_req_i[w_scan[c_id_w-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_scan[c_id_w-1:0];
      end
    end
  end

  issue_credit_counter #(
    .MAX_COUNT (MaxOutstanding),
    .CNT_WIDTH (CntWidth)
  ) u_credit (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (w_hs),
    .dec_i       (wb_valid_i),
    .cnt_o       (outstanding_o),
    .max_o       (w_credit_max),
    .underflow_o (w_underflow)
  );

  assign w_allowed   = !w_credit_max;
  assign w_locked    = (state_q == ARB_LOCKED);
  assign w_lock_drop = w_locked && !warp_req_i[lock_id_q];
  assign w_cur_id    = w_locked ? lock_id_q : w_sel_id;
  assign w_valid     = !rst_i && w_allowed && (w_locked ? warp_req_i[lock_id_q] : w_any_req);
  assign w_hs        = w_valid && eu_ready_i;

  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    ptr_d      = ptr_q;
    err_d      = err_q | w_underflow | w_lock_drop;
    warp_gnt_o = '0;
    case (state_q)
      ARB_IDLE: begin
        if (w_valid && !eu_ready_i) begin
          state_d   = ARB_LOCKED;
          lock_id_d = w_sel_id;
        end
      end
      ARB_LOCKED: begin
        if (w_hs || w_lock_drop) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (w_hs) begin
      warp_gnt_o[w_cur_id] = 1'b1;
      ptr_d = (w_cur_id == c_last_id) ? '0 : w_cur_id + c_id_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign eu_valid_o   = w_valid;
  assign eu_warp_id_o = w_cur_id;
  assign eu_data_o    = warp_data_i[w_cur_id*InstDataWidth +: InstDataWidth];
  assign err_o        = err_q;

`ifdef BGPU_ISSUE_PERF_EN
  logic [31:0] perf_stall_q;

  for (genvar w = 0; w < int'(NumWarps); w++) begin : g_perf_issue
    logic [31:0] issue_cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i)              issue_cnt_q <= '0;
      else if (warp_gnt_o[w]) issue_cnt_q <= issue_cnt_q + 32'd1;
    end
    assign perf_issue_cnt_o[w*32 +: 32] = issue_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                        perf_stall_q <= '0;
    else if (w_any_req && !w_allowed) perf_stall_q <= perf_stall_q + 32'd1;
  end

  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
`default_nettype wire
